// File: rtl/oled_refresh_ctrl.sv
// Display refresh sequencer: holds the newest frequency word, converts it to BCD by
// sequential double-dabble on each refresh tick and hands it to the OLED driver via req/ack.
`timescale 1ns/1ps

module oled_refresh_digit (
    input  logic [3:0] d,
    output logic [3:0] adj
);
    assign adj = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module oled_refresh_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int REFRESH_HZ  = 4,
    parameter int DATA_W      = 27,
    parameter int DIGITS      = 9
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DATA_W-1:0]     freq_in,
    input  logic                  freq_valid,
    input  logic [1:0]            mode_in,
    output logic                  upd_req,
    input  logic                  upd_ack,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     lz_mask,
    output logic [1:0]            mode_out,
    output logic                  busy
);
    localparam int TICK_DIV = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam int BIT_W    = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, LATCH, CONV, PRESENT} state_t;

    typedef struct packed {
        logic [DIGITS-1:0][3:0] bcd;
        logic [DIGITS-1:0]      lz;
        logic [1:0]             mode;
    } disp_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt;
    logic                   tick, tick_pend, pending, start, conv_last;
    logic [DATA_W-1:0]      shadow, work;
    logic [BIT_W-1:0]       bit_cnt;
    logic [1:0]             mode_lat;
    logic [DIGITS-1:0][3:0] bcd_w, bcd_adj, bcd_nx;
    logic [4*DIGITS-1:0]    adj_flat;
    logic [DIGITS-1:0]      lz_nx;
    logic                   hi_zero;
    disp_t                  disp_q;

    assign tick      = (cnt == CNT_W'(TICK_DIV - 1));
    assign conv_last = (bit_cnt == BIT_W'(DATA_W - 1));
    assign start     = (tick || tick_pend) && (pending || (mode_in != disp_q.mode));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cnt <= '0;
        else            cnt <= tick ? '0 : cnt + 1'b1;
    end

    // Shadow keeps loading in every state; a strobe during LATCH re-arms pending.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow  <= '0;
            pending <= 1'b0;
        end else if (freq_valid) begin
            shadow  <= freq_in;
            pending <= 1'b1;
        end else if (state_q == LATCH) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)             tick_pend <= 1'b0;
        else if (state_q == IDLE)   tick_pend <= 1'b0;
        else if (tick)              tick_pend <= 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE:    if (start)     state_d = LATCH;
            LATCH:                  state_d = CONV;
            CONV:    if (conv_last) state_d = PRESENT;
            PRESENT: if (upd_ack)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            oled_refresh_digit u_dig (.d(bcd_w[g]), .adj(bcd_adj[g]));
        end
    endgenerate

    assign adj_flat = bcd_adj;
    assign bcd_nx   = {adj_flat[4*DIGITS-2:0], work[DATA_W-1]};

    always_comb begin
        hi_zero  = 1'b1;
        lz_nx    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero  = hi_zero && (bcd_nx[i] == 4'd0);
            lz_nx[i] = hi_zero;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            work     <= '0;
            bcd_w    <= '0;
            bit_cnt  <= '0;
            mode_lat <= 2'd0;
        end else begin
            case (state_q)
                LATCH: begin
                    work     <= shadow;
                    bcd_w    <= '0;
                    bit_cnt  <= '0;
                    mode_lat <= mode_in;
                end
                CONV: begin
                    work    <= {work[DATA_W-2:0], 1'b0};
                    bcd_w   <= bcd_nx;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the final conversion step so they appear with upd_req.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_q  <= '{bcd: '0, lz: {{(DIGITS-1){1'b1}}, 1'b0}, mode: 2'd0};
            upd_req <= 1'b0;
        end else if (state_q == CONV && conv_last) begin
            disp_q  <= '{bcd: bcd_nx, lz: lz_nx, mode: mode_lat};
            upd_req <= 1'b1;
        end else if (state_q == PRESENT && upd_ack) begin
            upd_req <= 1'b0;
        end
    end

    assign bcd_out  = disp_q.bcd;
    assign lz_mask  = disp_q.lz;
    assign mode_out = disp_q.mode;

    // DIGITS is sized so the top nibble can never carry out of the shift.
    top_no_carry: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        !(state_q == CONV && adj_flat[4*DIGITS-1]));

endmodule

// File: tb/tb_oled_refresh_ctrl.sv
// Scoreboarded bench for oled_refresh_ctrl: stimulus pushes expected updates, a monitor
// pops and compares on each rising upd_req.
`timescale 1ns/1ps

module tb_oled_refresh_ctrl;
    localparam int DATA_W = 27;
    localparam int DIGITS = 9;
    localparam int TICK   = 64;

    typedef struct {
        logic [35:0] bcd;
        logic [8:0]  lz;
        logic [1:0]  mode;
        int          tick;
    } exp_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [DATA_W-1:0] freq_in = '0;
    logic              freq_valid = 1'b0;
    logic [1:0]        mode_in = 2'd0;
    logic              upd_req;
    logic              upd_ack = 1'b0;
    logic [35:0]       bcd_out;
    logic [8:0]        lz_mask;
    logic [1:0]        mode_out;
    logic              busy;

    oled_refresh_ctrl #(.CLK_FREQ_HZ(6400), .REFRESH_HZ(100), .DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .freq_in(freq_in), .freq_valid(freq_valid),
        .mode_in(mode_in), .upd_req(upd_req), .upd_ack(upd_ack), .bcd_out(bcd_out),
        .lz_mask(lz_mask), .mode_out(mode_out), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    int tcnt = 0;
    int n_chk = 0, n_pass = 0, rises = 0;
    exp_t q[$];
    exp_t e;
    logic prev_req = 1'b0;
    logic [1:0] cur_m = 2'd0;
    longint last_v = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Refresh phase: ticks every TICK cycles counted from reset release.
    always @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) tcnt <= 0;
        else            tcnt <= (tcnt == TICK - 1) ? 0 : tcnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input longint v, input logic [1:0] m, input int t);
        exp_t r;
        longint p = 1;
        r.bcd = '0;
        r.lz = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r.bcd[4*i +: 4] = 4'((v / p) % 10);
            if (i > 0 && v < p) r.lz[i] = 1'b1;
            p = p * 10;
        end
        r.mode = m;
        r.tick = t;
        return r;
    endfunction

    always @(negedge sys_clk) begin
        if (sys_rst_n && upd_req && !prev_req) begin
            rises++;
            if (q.size() == 0) check("unexpected_update", 64'd1, 64'd0);
            else begin
                e = q.pop_front();
                check("bcd_out", 64'(bcd_out), 64'(e.bcd));
                check("lz_mask", 64'(lz_mask), 64'(e.lz));
                check("mode_out", 64'(mode_out), 64'(e.mode));
                if (e.tick >= 0) check("latency", 64'(cyc - e.tick), 64'd29);
            end
        end
        prev_req = upd_req;
    end

    task automatic send(input longint v, input logic [1:0] m);
        @(negedge sys_clk);
        freq_in = DATA_W'(v); freq_valid = 1'b1; mode_in = m;
        @(negedge sys_clk);
        freq_valid = 1'b0;
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int i = 0; i < 2 * TICK; i++) begin
            if (tcnt == TICK - 1) begin t = cyc; break; end
            @(negedge sys_clk);
        end
        if (t < 0) check("tick_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (upd_req) begin ok = 1'b1; break; end
            @(negedge sys_clk);
        end
        if (!ok) check("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic handshake(input int delay);
        bit ok, stable;
        logic [48:0] snap;
        wait_req(ok);
        if (ok) begin
            check("busy_present", 64'(busy), 64'd1);
            snap = {bcd_out, lz_mask, mode_out, upd_req, busy};
            stable = 1'b1;
            for (int i = 0; i < delay; i++) begin
                @(negedge sys_clk);
                if ({bcd_out, lz_mask, mode_out, upd_req, busy} !== snap) stable = 1'b0;
            end
            check("hold_stable", 64'(stable), 64'd1);
            upd_ack = 1'b1;
            @(negedge sys_clk);
            upd_ack = 1'b0;
            check("req_drop", 64'(upd_req), 64'd0);
            check("out_after_ack", 64'({bcd_out, lz_mask, mode_out}), 64'(snap[48:2]));
        end
    endtask

    task automatic update(input longint v, input int delay);
        int t;
        send(v, cur_m);
        wait_tick(t);
        q.push_back(model(v, cur_m, t));
        last_v = v;
        handshake(delay);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, r0, nm;
        longint v;
        longint bnd[7];
        bnd = '{0, 1, 9, 10, 99_999_999, 100_000_000, 134_217_727};

        repeat (3) @(negedge sys_clk);
        check("rst_req", 64'(upd_req), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_lz", 64'(lz_mask), 64'h1FE);
        check("rst_mode", 64'(mode_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        sys_rst_n = 1'b1;
        repeat (3 * TICK) @(negedge sys_clk);
        check("idle_no_update", 64'(rises), 64'd0);
        check("idle_not_busy", 64'(busy), 64'd0);

        update(123_456_789, 0);
        update(0, 1);
        update(134_217_727, 2);
        update(1000, 0);

        // Stall: newest value wins while the driver withholds ack.
        begin
            bit ok, stable;
            logic [47:0] snap;
            send(42, cur_m);
            wait_tick(t);
            q.push_back(model(42, cur_m, t));
            wait_req(ok);
            snap = {bcd_out, lz_mask, mode_out, upd_req};
            stable = 1'b1;
            fork
                begin
                    repeat (20) @(negedge sys_clk);
                    send(5, cur_m);
                    repeat (60) @(negedge sys_clk);
                    send(77, cur_m);
                end
                for (int i = 0; i < 3 * TICK; i++) begin
                    @(negedge sys_clk);
                    if ({bcd_out, lz_mask, mode_out, upd_req} !== snap) stable = 1'b0;
                end
            join
            check("stall_stable", 64'(stable), 64'd1);
            q.push_back(model(77, cur_m, -1));
            r0 = rises;
            upd_ack = 1'b1;
            @(negedge sys_clk);
            upd_ack = 1'b0;
            check("stall_req_drop", 64'(upd_req), 64'd0);
            handshake(0);
            last_v = 77;
            repeat (3 * TICK) @(negedge sys_clk);
            check("stall_one_update", 64'(rises - r0), 64'd1);
        end

        // Mode change alone triggers a refresh with the same digits.
        @(negedge sys_clk);
        mode_in = 2'd2; cur_m = 2'd2;
        q.push_back(model(last_v, 2'd2, -1));
        handshake(2);

        // A strobe during LATCH is deferred to the following refresh.
        send(31_415, cur_m);
        wait_tick(t);
        q.push_back(model(31_415, cur_m, t));
        @(negedge sys_clk);
        check("latch_busy", 64'(busy), 64'd1);
        freq_in = 27'd271_828; freq_valid = 1'b1;
        @(negedge sys_clk);
        freq_valid = 1'b0;
        q.push_back(model(271_828, cur_m, -1));
        handshake(1);
        handshake(0);
        last_v = 271_828;

        for (int it = 0; it < 16; it++) begin
            repeat ($urandom_range(0, 70)) @(negedge sys_clk);
            v = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 6)]
                                            : longint'($urandom & 32'h07FF_FFFF);
            nm = $urandom_range(0, 3);
            if (2'(nm) == cur_m) begin
                update(v, $urandom_range(0, 5));
            end else begin
                cur_m = 2'(nm);
                send(v, cur_m);
                q.push_back(model(v, cur_m, -1));
                last_v = v;
                handshake($urandom_range(0, 5));
            end
        end

        // Reset in CONV cycle 10 aborts the conversion.
        send(999, cur_m);
        wait_tick(t);
        repeat (11) @(negedge sys_clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        r0 = rises;
        sys_rst_n = 1'b0;
        mode_in = 2'd0;
        #1;
        check("midrst_req", 64'(upd_req), 64'd0);
        check("midrst_bcd", 64'(bcd_out), 64'd0);
        check("midrst_lz", 64'(lz_mask), 64'h1FE);
        check("midrst_mode", 64'(mode_out), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3 * TICK) @(negedge sys_clk);
        check("midrst_no_update", 64'(rises - r0), 64'd0);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
